// File: rtl/cic_disrst_ctrl_if.sv
// Sample stream, filter drive and result bundle
// of the CIC flush/calibrate sequencer.
interface cic_disrst_ctrl_if #(
   parameter int W = 25
);
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic         cal_req;
   logic         cal_done;
   logic         cic_en;
   logic [W-1:0] cic_data;
   logic [W-1:0] cic_o;
   logic         out_valid;
   logic [W-1:0] out_data;

   modport master (
      output in_valid,
      output in_data,
      output cal_req,
      output cic_o,
      input  in_ready,
      input  cal_done,
      input  cic_en,
      input  cic_data,
      input  out_valid,
      input  out_data
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  cal_req,
      input  cic_o,
      output in_ready,
      output cal_done,
      output cic_en,
      output cic_data,
      output out_valid,
      output out_data
   );
endinterface

// File: rtl/cic_disrst_ctrl.sv
// Flush/calibrate sequencer and offset corrector
// for the reset-less interleaved CIC moving-sum filter.
module cic_disrst_ctrl #(
   parameter int width_H = 5,
   parameter int width_W = 20,
   parameter int N       = 32,
   parameter int DEC     = 1
) (
   input logic clk,
   input logic rst_n,
   cic_disrst_ctrl_if.slave bus
);
   localparam int W  = width_H + width_W;
   localparam int F  = N + 6;
   localparam int FW = $clog2(F + 2);
   localparam int DW = (DEC > 1) ? $clog2(DEC) : 1;

   typedef enum logic [1:0] {
      FLUSH = 2'd0,
      DRAIN = 2'd1,
      RUN   = 2'd2
   } state_t;

   state_t state;
   state_t state_nx;

   logic [FW-1:0] fcnt;
   logic [1:0]    skip;
   logic [DW-1:0] dcnt;
   logic          par;
   logic          en_d;
   logic [W-1:0]  off [2];

   logic          cic_en_q;
   logic [W-1:0]  cic_data_q;
   logic          out_valid_q;
   logic [W-1:0]  out_data_q;

   logic          issue;
   logic          drain;
   logic          run;
   logic          last_issue;
   logic          drain_done;
   logic          xfer;
   logic          emit;
   logic [W-1:0]  corr;

   assign last_issue = issue
                     && (fcnt == FW'(F - 1));
   assign drain_done = fcnt == FW'(F + 1);
   assign xfer       = run & bus.in_valid;

   // cic_o and par both describe the latest enable
   assign corr = bus.cic_o - off[par];

   assign emit = run
               & ~bus.cal_req
               & en_d
               & (skip == 2'd0)
               & (dcnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FLUSH;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         FLUSH: begin
            if (last_issue) state_nx = DRAIN;
         end
         DRAIN: begin
            if (drain_done) state_nx = RUN;
         end
         RUN: begin
            if (bus.cal_req) state_nx = FLUSH;
         end
         default: state_nx = FLUSH;
      endcase
   end

   always_comb begin
      issue = 1'b0;
      drain = 1'b0;
      run   = 1'b0;
      unique case (state)
         FLUSH:   issue = 1'b1;
         DRAIN:   drain = 1'b1;
         RUN:     run   = 1'b1;
         default: issue = 1'b0;
      endcase
   end

   // counts flush enables, then the two drain cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt <= '0;
      end else if (run) begin
         fcnt <= '0;
      end else begin
         fcnt <= fcnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cic_en_q   <= 1'b0;
         cic_data_q <= '0;
         en_d       <= 1'b0;
         par        <= 1'b0;
      end else begin
         cic_en_q   <= issue | xfer;
         cic_data_q <= xfer ? bus.in_data : '0;
         en_d       <= cic_en_q;
         if (cic_en_q) par <= ~par;
      end
   end

   // last two flush results win; earlier ones are overwritten
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         off[0] <= '0;
         off[1] <= '0;
      end else if (en_d && !run) begin
         off[par] <= bus.cic_o;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skip <= 2'd3;
         dcnt <= '0;
      end else if (drain) begin
         skip <= 2'd3;
         dcnt <= '0;
      end else if (run && en_d) begin
         if (skip != 2'd0) begin
            skip <= skip - 2'd1;
         end else if (dcnt == DW'(DEC - 1)) begin
            dcnt <= '0;
         end else begin
            dcnt <= dcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= emit;
         if (emit) out_data_q <= corr;
      end
   end

   assign bus.in_ready  = run;
   assign bus.cal_done  = run;
   assign bus.cic_en    = cic_en_q;
   assign bus.cic_data  = cic_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_cic_disrst_ctrl.sv
// Bench: two controllers (DEC=1, DEC=4) each driving a modelled
// reset-less CIC, checked against a moving-window sum reference.
module tb_cic_disrst_ctrl;
   localparam int WH = 5;
   localparam int WP = 20;
   localparam int W  = WH + WP;
   localparam int N  = 32;
   localparam int F  = N + 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         iv = 1'b0;
   logic [W-1:0] idat = '0;
   logic         creq = 1'b0;

   cic_disrst_ctrl_if #(.W(W)) b0 ();
   cic_disrst_ctrl_if #(.W(W)) b1 ();

   cic_disrst_ctrl #(
      .width_H(WH), .width_W(WP), .N(N), .DEC(1)
   ) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

   cic_disrst_ctrl #(
      .width_H(WH), .width_W(WP), .N(N), .DEC(4)
   ) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

   // ---------------- filter models ----------------
   logic [W-1:0] dl   [2][N];
   logic [W-1:0] acc  [2][2];
   logic [W-1:0] pr   [2][3];
   logic [W-1:0] fo   [2];
   logic         ph   [2];
   logic [W-1:0] eoff [2][2];
   int           ecnt [2];
   logic         fen  [2];
   logic [W-1:0] fin  [2];
   logic         loaded = 1'b0;

   assign fen[0] = b0.cic_en;
   assign fen[1] = b1.cic_en;
   assign fin[0] = b0.cic_data;
   assign fin[1] = b1.cic_data;

   assign b0.in_valid = iv;
   assign b1.in_valid = iv;
   assign b0.in_data  = idat;
   assign b1.in_data  = idat;
   assign b0.cal_req  = creq;
   assign b1.cal_req  = creq;
   assign b0.cic_o    = fo[0];
   assign b1.cic_o    = fo[1];

   always @(posedge clk) begin
      logic [W-1:0] z;
      if (!loaded) begin
         for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++)
               dl[d][i] = W'($urandom);
            acc[d][0] = W'($urandom);
            acc[d][1] = W'($urandom);
            for (int i = 0; i < 3; i++)
               pr[d][i] = W'($urandom);
            fo[d] <= W'($urandom);
            ph[d] = 1'($urandom);
            ecnt[d] = 0;
         end
         loaded = 1'b1;
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
               ecnt[d] = 0;
            end else if (fen[d]) begin
               z = fin[d] - dl[d][N-1];
               for (int i = N - 1; i > 0; i--)
                  dl[d][i] = dl[d][i-1];
               dl[d][0] = fin[d];
               acc[d][ph[d]] = acc[d][ph[d]] + z;
               fo[d] <= pr[d][2];
               eoff[d][(ecnt[d] + 1) % 2] = pr[d][2];
               ecnt[d]++;
               pr[d][2] = pr[d][1];
               pr[d][1] = pr[d][0];
               pr[d][0] = acc[d][ph[d]];
               ph[d] = ~ph[d];
            end
         end
      end
   end

   // ---------------- reference model ----------------
   typedef struct {
      int           due;
      logic [W-1:0] v;
      bit           e1;
   } exp_t;

   exp_t         pq [$];
   logic [W-1:0] hist [$];
   int           t;
   int           fs;
   int           rs;
   bit           px;
   logic [W-1:0] pdat;
   int           npass = 0;
   int           ntot = 0;

   task automatic ck(input string tag,
                     input logic [W-1:0] o,
                     input logic [W-1:0] e);
      ntot++;
      assert (o === e) npass++;
      else $error("FAIL %s t=%0d got %h exp %h",
                  tag, t, o, e);
   endtask

   function automatic logic [W-1:0] wsum(input int m);
      logic [W-1:0] s;
      s = '0;
      for (int i = m; i >= 0 && i > m - N; i -= 2)
         s = s + hist[i];
      return s;
   endfunction

   task automatic chk();
      bit           run;
      bit           een;
      bit           ev;
      exp_t         e;
      run = (t >= rs);
      een = (t >= fs && t < fs + F) || px;
      ev  = 1'b0;
      e   = '{0, '0, 1'b0};
      if (pq.size() > 0 && pq[0].due == t) begin
         ev = 1'b1;
         e  = pq.pop_front();
      end
      ck("in_ready0", W'(b0.in_ready), W'(run));
      ck("cal_done1", W'(b1.cal_done), W'(run));
      ck("cic_en0", W'(b0.cic_en), W'(een));
      ck("cic_en1", W'(b1.cic_en), W'(een));
      if (een) begin
         ck("cic_data0", b0.cic_data, px ? pdat : '0);
         ck("cic_data1", b1.cic_data, px ? pdat : '0);
      end
      ck("ovalid0", W'(b0.out_valid), W'(ev));
      ck("ovalid1", W'(b1.out_valid), W'(ev && e.e1));
      if (ev) ck("odata0", b0.out_data, e.v);
      if (ev && e.e1) ck("odata1", b1.out_data, e.v);
      if (t == rs) begin
         ck("off0_0", dut0.off[0], eoff[0][0]);
         ck("off0_1", dut0.off[1], eoff[0][1]);
         ck("off1_0", dut1.off[0], eoff[1][0]);
         ck("off1_1", dut1.off[1], eoff[1][1]);
      end
   endtask

   task automatic cyc(input bit v,
                      input logic [W-1:0] d,
                      input bit cr);
      bit x;
      int m;
      exp_t e;
      chk();
      iv   = v;
      idat = d;
      creq = cr;
      x = v && (t >= rs);
      if (x) begin
         hist.push_back(d);
         m = hist.size() - 4;
         if (m >= 0) begin
            e.due = t + 3;
            e.v   = wsum(m);
            e.e1  = (m % 4) == 0;
            pq.push_back(e);
         end
      end
      if (cr && t >= rs) begin
         fs = t + 2;
         rs = t + F + 3;
         while (pq.size() > 0 && pq[pq.size()-1].due > t)
            void'(pq.pop_back());
         hist.delete();
      end
      px   = x;
      pdat = d;
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic zchk();
      ck("rst_en0", W'(b0.cic_en), '0);
      ck("rst_dat0", b0.cic_data, '0);
      ck("rst_rdy0", W'(b0.in_ready), '0);
      ck("rst_ov0", W'(b0.out_valid), '0);
      ck("rst_od0", b0.out_data, '0);
      ck("rst_cd0", W'(b0.cal_done), '0);
      ck("rst_od1", b1.out_data, '0);
      ck("rst_ov1", W'(b1.out_valid), '0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      iv    = 1'b0;
      creq  = 1'b0;
      #1;
      zchk();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      t  = -1;
      fs = 0;
      rs = F + 1;
      px = 1'b0;
      hist.delete();
      pq.delete();
   endtask

   task automatic idle_flush(input string tag);
      int hi;
      hi = 0;
      for (int i = 0; i < F + 5; i++) begin
         if (b0.cic_en) hi++;
         cyc(1'b0, W'($urandom), i == 5);
      end
      ck(tag, W'(hi), W'(F));
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++)
         cyc(1'b1, W'(1), 1'b0);
   endtask

   initial begin
      int lowc;
      logic [W-1:0] imp;
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      idle_flush("flush_len");

      step(45);
      ck("step_hold0", b0.out_data, W'(16));
      ck("step_hold1", b1.out_data, W'(16));
      for (int i = 0; i < 40; i++)
         cyc(1'b1, '0, 1'b0);

      imp = W'($urandom);
      for (int i = 0; i < 40; i++) begin
         while ($urandom_range(0, 1) == 0)
            cyc(1'b0, W'($urandom), 1'b0);
         cyc(1'b1, (i == 0) ? imp : '0, 1'b0);
      end

      for (int i = 0; i < 60; i++)
         cyc(1'($urandom), W'($urandom), 1'b0);

      for (int i = 0; i < 40; i++)
         cyc(1'b1, '0, 1'b0);
      step(10);
      cyc(1'b1, W'(1), 1'b1);
      lowc = 0;
      for (int i = 0; i < 50; i++) begin
         if (!b0.in_ready) lowc++;
         cyc(1'b0, '0, 1'b0);
      end
      ck("recal_len", W'(lowc), W'(F + 2));
      step(40);
      ck("recal_hold0", b0.out_data, W'(16));

      for (int i = 0; i < 7; i++)
         cyc(1'b1, W'($urandom), 1'b0);
      do_reset();
      idle_flush("reflush_len");
      step(40);
      ck("rst_hold0", b0.out_data, W'(16));
      ck("rst_hold1", b1.out_data, W'(16));
      for (int i = 0; i < 6; i++)
         cyc(1'b0, '0, 1'b0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
